servo_ramp_bank: RTL
====================

# servo_ramp_bank

Multi-channel servo driver with slew-limited pulse-width ramping. It generates NUM_CH independent servo PWM outputs from one shared frame counter. Each channel takes a 2-bit command (off/open/close/neutral) and steps its pulse width toward the commanded target at a programmable rate, with no overshoot. Pulse widths are frame-latched so outputs never glitch mid-period. It sits between the mechanism-control FSMs (claw, wrist, pan) and the servo pins, and replaces per-servo PWM instances.

## Interface
- NUM_CH, 4, number of servo channels
- CNT_W, 21, width of tick counters and pulse widths
- PERIOD_COUNT, 2_000_000, frame length in clk cycles (20 ms at 100 MHz)
- OPEN_TICKS, 100_000, pulse width for open (1 ms)
- NEUTRAL_TICKS, 150_000, pulse width for neutral, and the reset pulse width
- CLOSE_TICKS, 200_000, pulse width for close (2 ms)
- STEP_SIZE, 1, maximum pulse-width change per ramp tick
- STEP_DIV_BITS, 4, ramp tick every 2^STEP_DIV_BITS clk cycles

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous, active-low reset
- ctrl  in  2*NUM_CH  per-channel command, channel i at [2i+1:2i]: 00=off, 01=open, 10=close, 11=neutral
- pwm_out  out  NUM_CH  servo pulse outputs, registered
- settled  out  NUM_CH  per channel: 1 when off, or when the ramped width equals the goal
- frame_start  out  1  one-cycle pulse at the first cycle of each frame

## Operation
- Goal register per channel, loaded from ctrl every cycle: 00→0, 01→OPEN_TICKS, 10→CLOSE_TICKS, 11→NEUTRAL_TICKS.
- Shared prescaler, STEP_DIV_BITS wide, free-running. The ramp tick is asserted when the prescaler is all-ones.
- Ramp, per channel, on a ramp tick:
  - Applies only when goal≠0 and pw_ctrl≠goal.
  - pw_ctrl moves toward goal by min(STEP_SIZE, |goal−pw_ctrl|). It never crosses the goal.
  - Comparison is unsigned, CNT_W wide.
- Off (goal=0): pw_ctrl holds its value. The channel emits no pulse. When re-enabled, the ramp resumes from the held value.
- Period counter: 0..PERIOD_COUNT−1, wraps to 0.
- Frame latch, per channel: on the wrap cycle (count=PERIOD_COUNT−1), pw_frame ← (goal≠0 ? pw_ctrl : 0).
- pwm_out[i] ← (period_cnt < pw_frame[i]).
- frame_start ← (period_cnt == PERIOD_COUNT−1), so it is high while the registered count reads 0.
- settled[i] = (goal==0) || (pw_ctrl==goal). Combinational from registers.
- Channels are fully independent. A command change on one channel never disturbs another channel.

## Timing
Reset values (rst_n low, asynchronous):
- period_cnt=0, prescaler=0, goal=0, pw_ctrl=NEUTRAL_TICKS, pw_frame=0
- pwm_out=0, frame_start=0, settled=all 1s

Latencies:
- ctrl change → goal: 1 cycle.
- goal → first pw_ctrl step: on the next ramp tick, up to 2^STEP_DIV_BITS cycles later.
- pw_ctrl → output: takes effect at the next frame boundary.
- pwm_out rises on the cycle after the registered count reads 0, i.e. one cycle after frame_start.
- Pulse high time is exactly pw_frame cycles. pw_frame ≥ PERIOD_COUNT gives a constant-high output.
- A full ramp takes ceil(|Δ|/STEP_SIZE) ticks.

Boundary cases:
- Goal changes mid-ramp: the ramp re-targets on the next tick with no pause.
- ctrl→00 mid-frame: the current frame completes with the latched width. The following frame is low.
- Reset mid-frame: pwm_out drops immediately. After release, the first frame is low (pw_frame=0), and the ramp starts from NEUTRAL_TICKS.
- Release of rst_n: counting starts on the first clk edge after release.

## Configuration
- Macro SERVO_RAMP_BANK_RAMP_EN.
- Defined: slew-limited ramping as described above.
- Undefined:
  - The prescaler and step logic are omitted.
  - pw_ctrl ← goal on the cycle after goal≠0 (an immediate jump). It still holds when goal=0.
  - settled is 1 at most one cycle after the goal change.
  - Frame latching and all other behaviour are unchanged.

## Test plan
All scenarios use NUM_CH=2, PERIOD_COUNT=100, OPEN/NEUTRAL/CLOSE=10/15/20, STEP_SIZE=2, STEP_DIV_BITS=1, with RAMP_EN defined unless noted.

- Reset, then ctrl=11 on both channels → first frame pwm_out=0; every later frame has a 15-cycle pulse; settled=11.
- ch0 ctrl 11→10 → pw_ctrl steps 15,17,19,20 (no overshoot to 21), one step per 2 cycles; settled[0] falls, then rises when pw_ctrl=20; ch1 unchanged.
- ch0 ctrl→01 mid-ramp at 17 → pw_ctrl steps 15,13,11,10. Each frame's pulse equals the pw_ctrl value at that frame's wrap cycle.
- ch1 ctrl→00 at period_cnt=5 → current frame pulse completes at 15 cycles; the next frame is low; ctrl→11 restores 15 cycles with no ramp.
- rst_n asserted at period_cnt=7 while pwm_out=11 → pwm_out=00 immediately; after release, frame_start appears on the first registered count 0, and pw_ctrl=15.
- RAMP_EN undefined, ctrl 11→10 → pw_ctrl=20 two cycles after the ctrl change; the next frame has a 20-cycle pulse.

Source files
------------

// File: rtl/servo_ramp_bank.sv
// Multi-channel servo PWM bank with slew-limited, frame-latched pulse widths.
// Define SERVO_RAMP_BANK_RAMP_EN for ramping; otherwise widths jump straight to the goal.
module servo_ramp_bank #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CNT_W         = 21,
    parameter int unsigned PERIOD_COUNT  = 2_000_000,
    parameter int unsigned OPEN_TICKS    = 100_000,
    parameter int unsigned NEUTRAL_TICKS = 150_000,
    parameter int unsigned CLOSE_TICKS   = 200_000,
    parameter int unsigned STEP_SIZE     = 1,
    parameter int unsigned STEP_DIV_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2*NUM_CH-1:0] ctrl,
    output logic [NUM_CH-1:0]   pwm_out,
    output logic [NUM_CH-1:0]   settled,
    output logic                frame_start
);

    localparam logic [CNT_W-1:0] OpenW    = CNT_W'(OPEN_TICKS);
    localparam logic [CNT_W-1:0] NeutralW = CNT_W'(NEUTRAL_TICKS);
    localparam logic [CNT_W-1:0] CloseW   = CNT_W'(CLOSE_TICKS);
    localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(PERIOD_COUNT - 1);

    logic [CNT_W-1:0] period_cnt;
    logic             wrap;
    logic [CNT_W-1:0] goal     [NUM_CH];
    logic [CNT_W-1:0] pw_ctrl  [NUM_CH];
    logic [CNT_W-1:0] pw_frame [NUM_CH];
    logic [CNT_W-1:0] pw_next  [NUM_CH];

    assign wrap = (period_cnt == LastCnt);

    function automatic logic [CNT_W-1:0] decode_goal(input logic [1:0] cmd);
        logic [CNT_W-1:0] w;
        case (cmd)
            2'b01:   w = OpenW;
            2'b10:   w = CloseW;
            2'b11:   w = NeutralW;
            default: w = '0;
        endcase
        return w;
    endfunction

`ifdef SERVO_RAMP_BANK_RAMP_EN
    localparam logic [CNT_W-1:0] StepW = CNT_W'(STEP_SIZE);

    logic [STEP_DIV_BITS-1:0] prescaler;
    logic                     ramp_tick;

    assign ramp_tick = &prescaler;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Step toward the goal, clamping the last step so the goal is never crossed.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pw_next[i] = pw_ctrl[i];
            if (ramp_tick && (goal[i] != '0) && (pw_ctrl[i] != goal[i])) begin
                if (goal[i] > pw_ctrl[i]) begin
                    pw_next[i] = ((goal[i] - pw_ctrl[i]) > StepW) ? pw_ctrl[i] + StepW : goal[i];
                end else begin
                    pw_next[i] = ((pw_ctrl[i] - goal[i]) > StepW) ? pw_ctrl[i] - StepW : goal[i];
                end
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{32'(STEP_SIZE), 32'(STEP_DIV_BITS)};

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pw_next[i] = (goal[i] != '0) ? goal[i] : pw_ctrl[i];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt  <= '0;
            frame_start <= 1'b0;
            pwm_out     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                goal[i]     <= '0;
                pw_ctrl[i]  <= NeutralW;
                pw_frame[i] <= '0;
            end
        end else begin
            period_cnt  <= wrap ? '0 : period_cnt + 1'b1;
            frame_start <= wrap;
            for (int i = 0; i < NUM_CH; i++) begin
                goal[i]    <= decode_goal(ctrl[2*i +: 2]);
                pw_ctrl[i] <= pw_next[i];
                // Width only changes at the frame boundary so pulses never glitch.
                if (wrap) begin
                    pw_frame[i] <= (goal[i] != '0) ? pw_ctrl[i] : '0;
                end
                pwm_out[i] <= (period_cnt < pw_frame[i]);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            settled[i] = (goal[i] == '0) || (pw_ctrl[i] == goal[i]);
        end
    end

endmodule
